log_capture_ctrl: RTL and testbench

- Sequences one capture into the logging block RAM, then serves read-back of that RAM to the register file.
- Sits between reg_file, which supplies the start/abort/config strobes and issues reads, and block_ram_control, which receives this block's write-enable, address and read-enable.
- Arms on a software start, waits for a trigger (immediate, or receiver sync done), then writes one RAM word per rate tick until the programmed length is reached.
- Flags done and accepts single-word read requests.

---
 rtl/log_capture_ctrl.sv | 152 +++++++++++++++
 tb/tb_log_capture_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/log_capture_ctrl.sv
// Capture sequencer for the logging block RAM: arm, wait for a trigger, write one word per
// rate tick up to the programmed length, then serve single-word read-back to reg_file.
module log_capture_ctrl #(
  parameter int unsigned RAM_DEPTH   = 32768,
  parameter int unsigned NBT_ADRS    = $clog2(RAM_DEPTH),
  parameter int unsigned ARM_TIMEOUT = 2**24
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_trig_mode,
  input  logic                i_sync_done,
  input  logic                i_rate_tick,
  input  logic [NBT_ADRS:0]   i_capture_len,
  input  logic                i_rd_req,
  input  logic [NBT_ADRS-1:0] i_rd_adrs,
  output logic                o_en_write,
  output logic [NBT_ADRS-1:0] o_wr_adrs,
  output logic                o_en_read,
  output logic [NBT_ADRS-1:0] o_rd_adrs,
  output logic                o_rd_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic [NBT_ADRS:0]   o_wr_count
);

  localparam int unsigned TmoW = $clog2(ARM_TIMEOUT) + 1;
  localparam logic [NBT_ADRS:0] LenMax = (NBT_ADRS + 1)'(RAM_DEPTH);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e                state_q, state_d;
  logic                  trig_q, trig_d;
  logic [NBT_ADRS:0]     len_q, len_d;
  logic                  sync_prev_q, sync_prev_d;
  logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [NBT_ADRS:0]     count_q, count_d;
  logic                  en_write_q, en_write_d;
  logic [NBT_ADRS-1:0]   wr_adrs_q, wr_adrs_d;
  logic                  en_read_q, en_read_d;
  logic [NBT_ADRS-1:0]   rd_adrs_q, rd_adrs_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_busy;
  logic                  sync_rise;

  assign rd_busy   = en_read_q | rd_valid_q;
  assign sync_rise = i_sync_done & ~sync_prev_q;

  always_comb begin
    state_d     = state_q;
    trig_d      = trig_q;
    len_d       = len_q;
    sync_prev_d = sync_prev_q;
    tmo_cnt_d   = tmo_cnt_q;
    timeout_d   = timeout_q;
    count_d     = count_q;
    en_write_d  = 1'b0;
    wr_adrs_d   = wr_adrs_q;
    en_read_d   = 1'b0;
    rd_adrs_d   = rd_adrs_q;
    rd_valid_d  = en_read_q;

    if (i_abort) begin
      // Abort beats start, trigger and tick; the write count is kept for software.
      state_d    = StIdle;
      rd_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (i_start) begin
            state_d     = StArmed;
            trig_d      = i_trig_mode;
            len_d       = (i_capture_len == '0 || i_capture_len > LenMax) ? LenMax
                                                                          : i_capture_len;
            sync_prev_d = i_sync_done;
            tmo_cnt_d   = '0;
            timeout_d   = 1'b0;
            count_d     = '0;
          end else if (i_rd_req && !rd_busy) begin
            en_read_d = 1'b1;
            rd_adrs_d = i_rd_adrs;
          end
        end
        StArmed: begin
          tmo_cnt_d   = tmo_cnt_q + 1'b1;
          sync_prev_d = i_sync_done;
          if (!trig_q || sync_rise) begin
            state_d = StCapture;
          end else if (tmo_cnt_q == TmoLast) begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end
        end
        StCapture: begin
          if (count_q == len_q) begin
            state_d = StDone;
          end else if (i_rate_tick) begin
            en_write_d = 1'b1;
            wr_adrs_d  = count_q[NBT_ADRS-1:0];
            count_d    = count_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= StIdle;
      trig_q      <= 1'b0;
      len_q       <= LenMax;
      sync_prev_q <= 1'b0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
      count_q     <= '0;
      en_write_q  <= 1'b0;
      wr_adrs_q   <= '0;
      en_read_q   <= 1'b0;
      rd_adrs_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      len_q       <= len_d;
      sync_prev_q <= sync_prev_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
      count_q     <= count_d;
      en_write_q  <= en_write_d;
      wr_adrs_q   <= wr_adrs_d;
      en_read_q   <= en_read_d;
      rd_adrs_q   <= rd_adrs_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign o_en_write = en_write_q;
  assign o_wr_adrs  = wr_adrs_q;
  assign o_en_read  = en_read_q;
  assign o_rd_adrs  = rd_adrs_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = (state_q == StArmed) || (state_q == StCapture);
  assign o_done     = (state_q == StDone);
  assign o_timeout  = timeout_q;
  assign o_wr_count = count_q;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Scoreboard bench for log_capture_ctrl: expected writes/reads are queued when stimulus is
// driven and matched (address and cycle) when the DUT raises its enables.
module tb_log_capture_ctrl;

  localparam int unsigned Depth = 32768;
  localparam int unsigned Aw    = 15;

  logic          clk = 1'b0;
  logic          i_reset, i_start, i_abort, i_trig_mode, i_sync_done, i_rate_tick, i_rd_req;
  logic [Aw:0]   i_capture_len;
  logic [Aw-1:0] i_rd_adrs;
  logic          o_en_write, o_en_read, o_rd_valid, o_busy, o_done, o_timeout;
  logic [Aw-1:0] o_wr_adrs, o_rd_adrs;
  logic [Aw:0]   o_wr_count;

  log_capture_ctrl #(
    .RAM_DEPTH  (Depth),
    .ARM_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_trig_mode  (i_trig_mode),
    .i_sync_done  (i_sync_done),
    .i_rate_tick  (i_rate_tick),
    .i_capture_len(i_capture_len),
    .i_rd_req     (i_rd_req),
    .i_rd_adrs    (i_rd_adrs),
    .o_en_write   (o_en_write),
    .o_wr_adrs    (o_wr_adrs),
    .o_en_read    (o_en_read),
    .o_rd_adrs    (o_rd_adrs),
    .o_rd_valid   (o_rd_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_timeout    (o_timeout),
    .o_wr_count   (o_wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int adrs;
    int cyc;
  } exp_t;

  exp_t wr_q[$];
  exp_t rd_q[$];
  int   valid_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every enable must match the head of its queue, in address and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (o_en_write === 1'b1) begin
      if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else begin
        e = wr_q.pop_front();
        check("wr_adrs", 32'(o_wr_adrs), 32'(e.adrs));
        check("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (o_en_read === 1'b1) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else begin
        e = rd_q.pop_front();
        check("rd_adrs", 32'(o_rd_adrs), 32'(e.adrs));
        check("rd_cycle", 32'(cyc), 32'(e.cyc));
        valid_q.push_back(cyc + 1);
      end
    end
    if (o_rd_valid === 1'b1) begin
      if (valid_q.size() == 0) check("valid_unexpected", 32'd1, 32'd0);
      else check("valid_cycle", 32'(cyc), 32'(valid_q.pop_front()));
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_wr(input int adrs);
    exp_t e;
    e.adrs = adrs;
    e.cyc  = cyc + 1;
    wr_q.push_back(e);
  endtask

  task automatic push_rd(input int adrs);
    exp_t e;
    e.adrs = adrs;
    e.cyc  = cyc + 1;
    rd_q.push_back(e);
  endtask

  task automatic start(input logic mode, input int len);
    i_start       = 1'b1;
    i_trig_mode   = mode;
    i_capture_len = (Aw + 1)'(len);
    clk_n(1);
    i_start = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_trig_mode = 1'b0; i_sync_done = 1'b0;
    i_rate_tick = 1'b0; i_rd_req = 1'b0; i_capture_len = '0; i_rd_adrs = '0;
    clk_n(2);
    i_reset = 1'b0;
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_timeout", 32'(o_timeout), 0);
    check("rst_count", 32'(o_wr_count), 0);
    check("rst_en_write", 32'(o_en_write), 0);

    // len=4, immediate trigger, ticks every 3 cycles; a tick while ARMED must not write.
    start(1'b0, 4);
    check("s1_armed_busy", 32'(o_busy), 1);
    i_rate_tick = 1'b1;
    clk_n(1);
    i_rate_tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_rate_tick = 1'b1;
      push_wr(i);
      clk_n(1);
      i_rate_tick = 1'b0;
      if (i < 3) clk_n(2);
    end
    check("s1_count", 32'(o_wr_count), 4);
    check("s1_done_early", 32'(o_done), 0);
    i_rate_tick = 1'b1;
    clk_n(1);
    i_rate_tick = 1'b0;
    check("s1_done", 32'(o_done), 1);
    check("s1_busy", 32'(o_busy), 0);
    clk_n(2);

    // Read-back from DONE; a second request while in flight is dropped.
    i_rd_req = 1'b1; i_rd_adrs = 15'd5;
    push_rd(5);
    clk_n(1);
    i_rd_adrs = 15'd9;
    clk_n(1);
    i_rd_req = 1'b0;
    clk_n(3);
    check("s2_rd_drained", 32'(valid_q.size() + rd_q.size()), 0);

    // Sync already high at start must not trigger; only a fresh rise does. len=0 -> full RAM.
    i_sync_done = 1'b1;
    clk_n(2);
    start(1'b1, 0);
    i_rd_req = 1'b1; i_rd_adrs = 15'd3; i_rate_tick = 1'b1;
    clk_n(1);
    i_rd_req = 1'b0;
    i_start = 1'b1; i_trig_mode = 1'b0; i_capture_len = 16'd4;
    clk_n(1);
    i_start = 1'b0; i_rate_tick = 1'b0;
    clk_n(2);
    check("s3_still_armed", 32'(o_busy), 1);
    i_sync_done = 1'b0;
    clk_n(2);
    i_sync_done = 1'b1;
    clk_n(1);
    i_rate_tick = 1'b1;
    for (int i = 0; i < int'(Depth); i++) begin
      push_wr(i);
      clk_n(1);
    end
    i_rate_tick = 1'b0;
    check("s3_count", 32'(o_wr_count), Depth);
    check("s3_done_early", 32'(o_done), 0);
    clk_n(1);
    check("s3_done", 32'(o_done), 1);
    check("s3_wr_drained", 32'(wr_q.size()), 0);

    // Timeout: sync held high, no edge, 16 ARMED cycles then back to IDLE.
    start(1'b1, 8);
    i_rate_tick = 1'b1;
    clk_n(15);
    check("s4_busy_last", 32'(o_busy), 1);
    check("s4_timeout_early", 32'(o_timeout), 0);
    check("s4_count_cleared", 32'(o_wr_count), 0);
    clk_n(1);
    i_rate_tick = 1'b0;
    check("s4_timeout", 32'(o_timeout), 1);
    check("s4_busy", 32'(o_busy), 0);
    check("s4_done", 32'(o_done), 0);
    clk_n(3);
    check("s4_timeout_sticky", 32'(o_timeout), 1);

    // Abort together with a tick after 3 writes of len=8.
    start(1'b0, 8);
    check("s5_timeout_clr", 32'(o_timeout), 0);
    clk_n(1);
    for (int i = 0; i < 3; i++) begin
      i_rate_tick = 1'b1;
      push_wr(i);
      clk_n(1);
      i_rate_tick = 1'b0;
      clk_n(1);
    end
    i_rate_tick = 1'b1; i_abort = 1'b1;
    clk_n(1);
    i_rate_tick = 1'b0; i_abort = 1'b0;
    check("s5_busy", 32'(o_busy), 0);
    check("s5_done", 32'(o_done), 0);
    check("s5_count", 32'(o_wr_count), 3);
    i_rd_req = 1'b1; i_rd_adrs = 15'd7;
    push_rd(7);
    clk_n(1);
    i_rd_req = 1'b0;
    clk_n(3);

    // Reach DONE with len=1, then start+abort together: no capture.
    start(1'b0, 1);
    clk_n(1);
    i_rate_tick = 1'b1;
    push_wr(0);
    clk_n(1);
    i_rate_tick = 1'b0;
    clk_n(1);
    check("s6_done", 32'(o_done), 1);
    i_start = 1'b1; i_abort = 1'b1; i_capture_len = 16'd4;
    clk_n(1);
    i_start = 1'b0; i_abort = 1'b0;
    check("s6_abort_busy", 32'(o_busy), 0);
    check("s6_abort_done", 32'(o_done), 0);
    i_rate_tick = 1'b1;
    clk_n(3);
    i_rate_tick = 1'b0;
    check("s6_no_capture", 32'(o_busy), 0);

    // Reset mid-capture.
    start(1'b0, 8);
    clk_n(1);
    i_rate_tick = 1'b1;
    push_wr(0);
    clk_n(1);
    i_reset = 1'b1;
    clk_n(1);
    i_reset = 1'b0; i_rate_tick = 1'b0;
    check("s7_busy", 32'(o_busy), 0);
    check("s7_count", 32'(o_wr_count), 0);
    check("s7_en_write", 32'(o_en_write), 0);
    check("s7_wr_adrs", 32'(o_wr_adrs), 0);
    clk_n(3);
    check("end_queues", 32'(wr_q.size() + rd_q.size() + valid_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
